// File: rtl/cpu.sv
// ---------------------------------------------------------------------------
// cpu -- minimal 8-bit accumulator processor (Phase-1 adding machine)
//
// Fetches and executes instructions from an external 64-byte unified
// instruction/data memory. Every instruction takes three cycles:
// FETCH -> DECODE -> EXECUTE.
//
// Instruction word: [7:6] opcode, [5:0] operand address A
//   00 LOAD  AC <- M[A]
//   01 ADD   AC <- (AC + M[A]) mod 256
//   10 STORE M[A] <- AC
//   11 JUMP  PC <- A
//
// Ports
//   clk          in   1  system clock, rising-edge
//   rst          in   1  asynchronous active-high reset
//   data_bus_in  in   8  memory read data (combinational, same cycle)
//   rd_mem       out  1  memory read strobe
//   wr_mem       out  1  memory write strobe (memory captures on the
//                        rising edge that ends the cycle)
//   adr_bus      out  6  memory address
//   data_bus_out out  8  write data, always the accumulator
//
// Configuration macro CPU_HALT_EN: when defined, a JUMP to its own address
// enters a HALT state that idles the buses until reset. When undefined the
// self-jump just refetches the same instruction every three cycles.
// ---------------------------------------------------------------------------
module cpu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_bus_in,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic [5:0] adr_bus,
  output logic [7:0] data_bus_out
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_DECODE  = 2'b01,
`ifdef CPU_HALT_EN
    S_EXECUTE = 2'b10,
    S_HALT    = 2'b11
`else
    S_EXECUTE = 2'b10
`endif
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  state_t     r_state;
  logic [5:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_ac;

  state_t     w_state_nxt;
  logic [5:0] w_pc_nxt;
  logic [7:0] w_ir_nxt;
  logic [7:0] w_ac_nxt;
  logic       w_rd;
  logic       w_wr;
  logic [5:0] w_adr;

  logic [1:0] w_opcode;
  logic [5:0] w_operand;
  logic [7:0] w_sum;

  assign w_opcode  = r_ir[7:6];
  assign w_operand = r_ir[5:0];
  // Eight-bit add; the carry out is simply discarded.
  assign w_sum     = r_ac + data_bus_in;

`ifdef CPU_HALT_EN
  // PC has already been advanced past the jump during FETCH, so the jump's
  // own address is PC-1 (modulo 64).
  logic [5:0] w_pc_prev;
  logic       w_self_jump;
  assign w_pc_prev   = r_pc - 6'd1;
  assign w_self_jump = (w_operand == w_pc_prev);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ac    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_ac    <= w_ac_nxt;
    end
  end

  // Next-state and bus decode
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_ac_nxt    = r_ac;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_adr       = w_operand;

    case (r_state)
      S_FETCH: begin
        w_rd        = 1'b1;
        w_adr       = r_pc;
        w_ir_nxt    = data_bus_in;
        w_pc_nxt    = r_pc + 6'd1;   // wraps 63 -> 0 naturally
        w_state_nxt = S_DECODE;
      end

      S_DECODE: begin
        w_state_nxt = S_EXECUTE;
      end

      S_EXECUTE: begin
        w_state_nxt = S_FETCH;
        case (w_opcode)
          OP_LOAD: begin
            w_rd     = 1'b1;
            w_ac_nxt = data_bus_in;
          end
          OP_ADD: begin
            w_rd     = 1'b1;
            w_ac_nxt = w_sum;
          end
          OP_STORE: begin
            w_wr = 1'b1;
          end
          OP_JUMP: begin
            w_pc_nxt = w_operand;
`ifdef CPU_HALT_EN
            if (w_self_jump) begin
              w_state_nxt = S_HALT;
            end
`endif
          end
          default: begin
            w_state_nxt = S_FETCH;
          end
        endcase
      end

`ifdef CPU_HALT_EN
      S_HALT: begin
        // Parked until reset: buses idle, address shows the PC.
        w_adr       = r_pc;
        w_state_nxt = S_HALT;
      end
`endif

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Reset forces every output low immediately, which also kills a write
  // strobe that was in flight when reset arrived.
  assign rd_mem       = w_rd & ~rst;
  assign wr_mem       = w_wr & ~rst;
  assign adr_bus      = rst ? 6'd0 : w_adr;
  assign data_bus_out = rst ? 8'd0 : r_ac;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_bus_in;
  logic       rd_mem;
  logic       wr_mem;
  logic [5:0] adr_bus;
  logic [7:0] data_bus_out;

  logic [7:0] mem [64];
  logic [7:0] mdl [64];

  int checks   = 0;
  int failures = 0;

  cpu dut (
    .clk          (clk),
    .rst          (rst),
    .data_bus_in  (data_bus_in),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .adr_bus      (adr_bus),
    .data_bus_out (data_bus_out)
  );

  always #10 clk = ~clk;

  // External memory: combinational read, write on rising edge.
  assign data_bus_in = mem[adr_bus];
  always @(posedge clk) begin
    if (wr_mem) mem[adr_bus] = data_bus_out;
  end

  typedef struct packed {
    logic [31:0] prog;    // M[3..0], byte 0 goes to M[0]
    logic [7:0]  d32;
    logic [7:0]  d33;
    logic [5:0]  chk_adr;
    logic [7:0]  chk_exp;
    logic [3:0]  wr_cnt;  // expected number of write cycles in 12 cycles
    logic [5:0]  wr_adr;  // address of the last write
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  endtask

  // Hold reset 100 ns, check the idle outputs, release, land in cycle 1.
  task automatic release_rst(input string name);
    rst = 1'b1;
    #100;
    chk({name, "_reset_out"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({name, "_first_fetch"}, {25'h0, rd_mem, adr_bus}, {25'h0, 1'b1, 6'd0});
  endtask

  function automatic logic [15:0] bus(input logic rd, input logic wr,
                                      input logic [5:0] a, input logic [7:0] d);
    return {rd, wr, a, d};
  endfunction

  // Instruction-level reference: per instruction, three expected bus cycles.
  task automatic run_random(input int iter, input int ninstr);
    logic [5:0] pc;
    logic [7:0] ac;
    logic [7:0] ir;
    logic [5:0] a;
    bit         halted;
    string      nm;
    start_test();
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      mdl[i] = mem[i];
    end
    nm = $sformatf("rand%0d", iter);
    release_rst(nm);
    pc = 6'd0;
    ac = 8'd0;
    halted = 1'b0;
    for (int n = 0; n < ninstr; n++) begin
      if (halted) begin
        chk({nm, "_halt"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(0, 0, pc, ac)});
        step();
        continue;
      end
      ir = mdl[pc];
      a  = ir[5:0];
      chk({nm, "_fetch"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(1, 0, pc, ac)});
      step();
      pc = pc + 6'd1;
      chk({nm, "_decode"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(0, 0, a, ac)});
      step();
      case (ir[7:6])
        2'b00: begin
          chk({nm, "_exec_ld"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(1, 0, a, ac)});
          ac = mdl[a];
        end
        2'b01: begin
          chk({nm, "_exec_add"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(1, 0, a, ac)});
          ac = 8'((int'(ac) + int'(mdl[a])) % 256);
        end
        2'b10: begin
          chk({nm, "_exec_st"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(0, 1, a, ac)});
          mdl[a] = ac;
        end
        default: begin
          chk({nm, "_exec_jmp"}, {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, {16'h0, bus(0, 0, a, ac)});
`ifdef CPU_HALT_EN
          if (a == pc - 6'd1) halted = 1'b1;
`endif
          pc = a;
        end
      endcase
      step();
    end
    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== mdl[i]) diffs++;
      chk({nm, "_mem_diffs"}, 32'(diffs), 32'd0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{prog: {8'h00, 8'h00, 8'hA1, 8'h20}, d32: 8'd7,   d33: 8'd0,
                chk_adr: 6'd33, chk_exp: 8'd7,   wr_cnt: 4'd1, wr_adr: 6'd33};
    vecs[1] = '{prog: {8'h00, 8'hA2, 8'h61, 8'h20}, d32: 8'd200, d33: 8'd100,
                chk_adr: 6'd34, chk_exp: 8'd44,  wr_cnt: 4'd1, wr_adr: 6'd34};
    vecs[2] = '{prog: {8'h00, 8'hA2, 8'h61, 8'h20}, d32: 8'd5,   d33: 8'd10,
                chk_adr: 6'd34, chk_exp: 8'd15,  wr_cnt: 4'd1, wr_adr: 6'd34};
    vecs[3] = '{prog: {8'hA2, 8'h61, 8'h61, 8'h20}, d32: 8'd1,   d33: 8'd127,
                chk_adr: 6'd34, chk_exp: 8'd255, wr_cnt: 4'd1, wr_adr: 6'd34};
    vecs[4] = '{prog: {8'h00, 8'hA2, 8'hC3, 8'h20}, d32: 8'd9,   d33: 8'd0,
                chk_adr: 6'd34, chk_exp: 8'd0,   wr_cnt: 4'd0, wr_adr: 6'd0};

    // Table-driven directed programs, 12 cycles each.
    for (int t = 0; t < 5; t++) begin
      int         nwr;
      logic [5:0] last_wadr;
      logic [7:0] at6;
      string      nm;
      nm = $sformatf("vec%0d", t);
      start_test();
      for (int b = 0; b < 4; b++) mem[b] = vecs[t].prog[8*b +: 8];
      mem[32] = vecs[t].d32;
      mem[33] = vecs[t].d33;
      release_rst(nm);
      nwr = 0;
      last_wadr = 6'd0;
      at6 = 8'd0;
      for (int c = 1; c <= 12; c++) begin
        if (wr_mem) begin
          nwr++;
          last_wadr = adr_bus;
        end
        step();
        if (c == 6) at6 = mem[vecs[t].chk_adr];
      end
      chk({nm, "_mem"}, 32'(mem[vecs[t].chk_adr]), 32'(vecs[t].chk_exp));
      chk({nm, "_wr_cycles"}, 32'(nwr), 32'(vecs[t].wr_cnt));
      if (vecs[t].wr_cnt != 4'd0)
        chk({nm, "_wr_adr"}, 32'(last_wadr), 32'(vecs[t].wr_adr));
      if (t == 0)
        chk({nm, "_mem_after_cyc6"}, 32'(at6), 32'd7);
    end

    // JUMP: next fetch at 5, addresses 1..4 never fetched.
    begin
      int bad;
      start_test();
      mem[0] = 8'hC5;
      release_rst("jump");
      bad = 0;
      for (int c = 1; c <= 12; c++) begin
        if (c == 4) chk("jump_target_fetch", {25'h0, rd_mem, adr_bus}, {25'h0, 1'b1, 6'd5});
        if (rd_mem && adr_bus >= 6'd1 && adr_bus <= 6'd4) bad++;
        step();
      end
      chk("jump_skipped_fetches", 32'(bad), 32'd0);
    end

    // PC wrap: 0 -> jump 62, then 62, 63, 0.
    start_test();
    mem[0]  = 8'hFE;
    mem[62] = 8'h20;
    mem[63] = 8'h61;
    release_rst("wrap");
    for (int c = 1; c <= 10; c++) begin
      if (c == 4)  chk("wrap_fetch62", {25'h0, rd_mem, adr_bus}, {25'h0, 1'b1, 6'd62});
      if (c == 7)  chk("wrap_fetch63", {25'h0, rd_mem, adr_bus}, {25'h0, 1'b1, 6'd63});
      if (c == 10) chk("wrap_fetch0",  {25'h0, rd_mem, adr_bus}, {25'h0, 1'b1, 6'd0});
      step();
    end

    // Fibonacci table.
    start_test();
    mem[32] = 8'd1;
    mem[33] = 8'd1;
    for (int i = 0; i < 7; i++) begin
      mem[3*i]     = {2'b00, 6'(32 + i)};
      mem[3*i + 1] = {2'b01, 6'(33 + i)};
      mem[3*i + 2] = {2'b10, 6'(34 + i)};
    end
    mem[21] = {2'b11, 6'd21};
    release_rst("fib");
    for (int c = 1; c <= 87; c++) step();
    begin
      int fa, fb, fc;
      fa = 1;
      fb = 1;
      chk("fib_m32", 32'(mem[32]), 32'd1);
      chk("fib_m33", 32'(mem[33]), 32'd1);
      for (int k = 34; k <= 40; k++) begin
        fc = fa + fb;
        chk($sformatf("fib_m%0d", k), 32'(mem[k]), 32'(fc));
        fa = fb;
        fb = fc;
      end
    end

    // Self-jump at address 0.
    start_test();
    mem[0] = 8'hC0;
    release_rst("selfjmp");
    for (int c = 1; c <= 15; c++) begin
`ifdef CPU_HALT_EN
      chk($sformatf("halt_cyc%0d", c), {30'h0, rd_mem, wr_mem},
          {30'h0, (c == 1), 1'b0});
`else
      chk($sformatf("selfjmp_cyc%0d", c), {24'h0, rd_mem, wr_mem, adr_bus},
          {24'h0, (c % 3 == 1), 1'b0, 6'd0});
`endif
      step();
    end

    // Reset in the middle of a STORE's EXECUTE cycle: no write.
    start_test();
    mem[0]  = 8'h20;
    mem[1]  = 8'hA1;
    mem[32] = 8'd9;
    release_rst("abort");
    for (int c = 1; c <= 5; c++) step();
    chk("abort_store_active", {24'h0, wr_mem, 1'b0, adr_bus}, {24'h0, 1'b1, 1'b0, 6'd33});
    rst = 1'b1;
    #1;
    chk("abort_outputs_low", {16'h0, rd_mem, wr_mem, adr_bus, data_bus_out}, 32'h0);
    step();
    chk("abort_no_write", 32'(mem[33]), 32'd0);
    release_rst("abort_restart");

    // Randomized programs against the instruction-level model.
    for (int it = 0; it < 4; it++) run_random(it, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
